// File: rtl/vga_display_driver_if.sv
// Colour and timing bundle between the upstream pattern generator and the VGA driver.
// The master side is the upstream source; the slave side is the display driver.
interface vga_display_driver_if;
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;
    logic [3:0] vga_red;
    logic [3:0] vga_green;
    logic [3:0] vga_blue;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;

    modport master (
        output red_in, green_in, blue_in,
        input  vga_red, vga_green, vga_blue, hsync, vsync, video_on,
        input  pixel_x, pixel_y, frame_start
    );

    modport slave (
        input  red_in, green_in, blue_in,
        output vga_red, vga_green, vga_blue, hsync, vsync, video_on,
        output pixel_x, pixel_y, frame_start
    );
endinterface

// File: rtl/vga_display_driver.sv
// VGA timing generator and output stage: divided pixel tick, h/v counters,
// registered active-low syncs and blanked colour, plus live pixel coordinates.
module vga_display_driver #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_display_driver_if.slave  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [9:0]       hCnt_q, hCnt_d;
    logic [9:0]       vCnt_q, vCnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             videoOn_q, videoOn_d;
    logic [3:0]       red_q, red_d;
    logic [3:0]       green_q, green_d;
    logic [3:0]       blue_q, blue_d;
    logic             pixTick;
    logic             active;

    // With CLK_DIV=1 the divider collapses to a constant tick.
    always_comb begin
        pixTick  = (divCnt_q == DIV_LAST);
        divCnt_d = pixTick ? '0 : divCnt_q + 1'b1;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        if (pixTick) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 10'd1;
            end else begin
                hCnt_d = hCnt_q + 10'd1;
            end
        end
    end

    // Decode of the current counter position; registered below every clk,
    // so colour changes mid-pixel reach the DAC without waiting for a tick.
    always_comb begin
        active    = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
        hsync_d   = !((hCnt_q >= HS_START) && (hCnt_q < HS_END));
        vsync_d   = !((vCnt_q >= VS_START) && (vCnt_q < VS_END));
        videoOn_d = active;
        red_d     = active ? vga.red_in   : 4'd0;
        green_d   = active ? vga.green_in : 4'd0;
        blue_d    = active ? vga.blue_in  : 4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt_q  <= '0;
            hCnt_q    <= '0;
            vCnt_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            videoOn_q <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            divCnt_q  <= divCnt_d;
            hCnt_q    <= hCnt_d;
            vCnt_q    <= vCnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            videoOn_q <= videoOn_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign vga.vga_red     = red_q;
    assign vga.vga_green   = green_q;
    assign vga.vga_blue    = blue_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = videoOn_q;
    assign vga.pixel_x     = hCnt_q;
    assign vga.pixel_y     = vCnt_q;
    assign vga.frame_start = pixTick && (hCnt_q == H_LAST) && (vCnt_q == V_LAST);

endmodule

// File: tb/tb_vga_display_driver.sv
// Randomized-colour bench for vga_display_driver: three builds (two tiny geometries
// with CLK_DIV=2 and 1, plus the full 640x480 build) checked against a cycle-count model.
module tb_vga_display_driver;

    typedef struct {
        int div;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
    } geom_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
    } obs_t;

    localparam int S_HA = 8, S_HFP = 2, S_HSW = 3, S_HBP = 2;
    localparam int S_VA = 5, S_VFP = 1, S_VSW = 2, S_VBP = 2;

    geom_t gA = '{2, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP};
    geom_t gB = '{1, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP};
    geom_t gC = '{4, 640, 16, 96, 48, 480, 10, 2, 33};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          assertCount = 0;
    int          failCount = 0;
    int          n = 0;
    logic [11:0] rgbNow = '0;

    vga_display_driver_if ifA ();
    vga_display_driver_if ifB ();
    vga_display_driver_if ifC ();

    vga_display_driver #(
        .CLK_DIV(2), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP)
    ) dutA (.clk(clk), .rst(rst), .vga(ifA.slave));

    vga_display_driver #(
        .CLK_DIV(1), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP)
    ) dutB (.clk(clk), .rst(rst), .vga(ifB.slave));

    vga_display_driver dutC (.clk(clk), .rst(rst), .vga(ifC.slave));

    always #5 clk = ~clk;

    // Expected outputs after 'cyc' rising edges since reset release, derived purely
    // from the pixel index (cyc / div) and the previously applied colour.
    function automatic obs_t model(input int cyc, input geom_t g, input logic [11:0] rgb);
        int   ht, vt, p, x, y, pp, xp, yp;
        logic on;
        obs_t e;
        ht = g.ha + g.hfp + g.hsw + g.hbp;
        vt = g.va + g.vfp + g.vsw + g.vbp;
        p  = cyc / g.div;
        x  = p % ht;
        y  = (p / ht) % vt;
        e.px = 10'(x);
        e.py = 10'(y);
        e.fs = ((cyc % g.div) == g.div - 1) && (x == ht - 1) && (y == vt - 1);
        if (cyc == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0;
            e.r = 4'd0; e.g = 4'd0; e.b = 4'd0;
        end else begin
            pp = (cyc - 1) / g.div;
            xp = pp % ht;
            yp = (pp / ht) % vt;
            on = (xp < g.ha) && (yp < g.va);
            e.von = on;
            e.hs  = !((xp >= g.ha + g.hfp) && (xp < g.ha + g.hfp + g.hsw));
            e.vs  = !((yp >= g.va + g.vfp) && (yp < g.va + g.vfp + g.vsw));
            e.r   = on ? rgb[11:8] : 4'd0;
            e.g   = on ? rgb[7:4]  : 4'd0;
            e.b   = on ? rgb[3:0]  : 4'd0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, observed, expected);
        end
    endtask

    task automatic checkDut(input string name, input obs_t obs, input obs_t exp);
        checkOutput({name, ".vga_red"},     32'(obs.r),   32'(exp.r));
        checkOutput({name, ".vga_green"},   32'(obs.g),   32'(exp.g));
        checkOutput({name, ".vga_blue"},    32'(obs.b),   32'(exp.b));
        checkOutput({name, ".hsync"},       32'(obs.hs),  32'(exp.hs));
        checkOutput({name, ".vsync"},       32'(obs.vs),  32'(exp.vs));
        checkOutput({name, ".video_on"},    32'(obs.von), 32'(exp.von));
        checkOutput({name, ".pixel_x"},     32'(obs.px),  32'(exp.px));
        checkOutput({name, ".pixel_y"},     32'(obs.py),  32'(exp.py));
        checkOutput({name, ".frame_start"}, 32'(obs.fs),  32'(exp.fs));
    endtask

    task automatic checkAllDuts(input int cyc);
        checkDut("div2", {ifA.vga_red, ifA.vga_green, ifA.vga_blue, ifA.hsync, ifA.vsync,
                          ifA.video_on, ifA.pixel_x, ifA.pixel_y, ifA.frame_start},
                 model(cyc, gA, rgbNow));
        checkDut("div1", {ifB.vga_red, ifB.vga_green, ifB.vga_blue, ifB.hsync, ifB.vsync,
                          ifB.video_on, ifB.pixel_x, ifB.pixel_y, ifB.frame_start},
                 model(cyc, gB, rgbNow));
        checkDut("full", {ifC.vga_red, ifC.vga_green, ifC.vga_blue, ifC.hsync, ifC.vsync,
                          ifC.video_on, ifC.pixel_x, ifC.pixel_y, ifC.frame_start},
                 model(cyc, gC, rgbNow));
    endtask

    task automatic applyStimulus(input logic [11:0] rgb);
        rgbNow = rgb;
        {ifA.red_in, ifA.green_in, ifA.blue_in} = rgb;
        {ifB.red_in, ifB.green_in, ifB.blue_in} = rgb;
        {ifC.red_in, ifC.green_in, ifC.blue_in} = rgb;
    endtask

    // Outputs are sampled on the falling edge, then the next colour is presented.
    task automatic runCycles(input int count, input bit holdConst);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            n++;
            checkAllDuts(n);
            if (holdConst)
                applyStimulus(12'hFA5);
            else
                applyStimulus(12'($urandom));
        end
    endtask

    initial begin
        applyStimulus(12'hFA5);
        repeat (3) @(negedge clk);
        n = 0;
        checkAllDuts(0);
        rst = 1'b1;
        runCycles(700, 1'b1);
        runCycles(3300 + int'($urandom_range(0, 200)), 1'b0);

        // Asynchronous reset away from any clock edge must clear outputs at once.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n = 0;
        checkAllDuts(0);
        @(negedge clk);
        applyStimulus(12'($urandom));
        repeat (2) @(negedge clk);
        checkAllDuts(0);
        rst = 1'b1;
        runCycles(4000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
